// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is always driven on data_o.
// Pointers carry one extra wrap bit so full and empty are told apart by subtraction alone.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       write_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       full_o,
    input  logic                       read_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     usage_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic [AW:0]      w_usage;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;

    // All flags derive from registered pointers, so no input reaches an output combinationally.
    always_comb begin
        w_usage = r_wr_ptr - r_rd_ptr;
        w_empty = (w_usage == '0);
        w_full  = (w_usage == (AW + 1)'(DEPTH));
        w_wr_en = write_i && !w_full;
        w_rd_en = read_i && !w_empty;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

    always_comb begin
        usage_o = w_usage;
        empty_o = w_empty;
        full_o  = w_full;
        data_o  = r_mem[r_rd_ptr[AW-1:0]];
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed stimulus for sync_fifo (DEPTH=4) against a queue-based reference model.
// The driver queues expected pops; a negedge monitor pops and compares when the DUT hands out a word.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             write_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             full_o;
    logic             read_i = 1'b0;
    logic [WIDTH-1:0] data_o;
    logic             empty_o;
    logic [2:0]       usage_o;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .write_i (write_i),
        .data_i  (data_i),
        .full_o  (full_o),
        .read_i  (read_i),
        .data_o  (data_o),
        .empty_o (empty_o),
        .usage_o (usage_o)
    );

    always #5 clk_i = ~clk_i;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int unsigned      n_checks = 0;
    int unsigned      n_fail   = 0;
    bit               check_en = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus, then advance the reference model past the edge.
    task automatic drive(input bit rst, input bit wr, input logic [WIDTH-1:0] d, input bit rd);
        int unsigned cnt;
        rst_i   = rst;
        write_i = wr;
        data_i  = d;
        read_i  = rd;
        if (!rst && rd && model_q.size() > 0) exp_q.push_back(model_q[0]);
        @(posedge clk_i);
        #1;
        cnt = model_q.size();
        if (rst) begin
            model_q.delete();
        end else begin
            if (rd && cnt > 0) void'(model_q.pop_front());
            if (wr && cnt < DEPTH) model_q.push_back(d);
        end
    endtask

    always @(negedge clk_i) begin
        if (check_en) begin
            check("usage", 32'(usage_o), model_q.size());
            check("empty", 32'(empty_o), (model_q.size() == 0) ? 1 : 0);
            check("full", 32'(full_o), (model_q.size() == DEPTH) ? 1 : 0);
            if (model_q.size() > 0) check("head", 32'(data_o), 32'(model_q[0]));
            if (read_i && !empty_o && !rst_i) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1, 0, '0, 0);
        check_en = 1'b1;

        // Fill, overflow, drain, underflow
        drive(0, 1, 8'h11, 0);
        drive(0, 1, 8'h22, 0);
        drive(0, 1, 8'h33, 0);
        drive(0, 1, 8'h44, 0);
        drive(0, 1, 8'h55, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);

        // Simultaneous access at usage 2, empty, and full
        drive(0, 1, 8'h01, 0);
        drive(0, 1, 8'h02, 0);
        drive(0, 1, 8'h03, 1);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        drive(0, 1, 8'h7E, 1);
        drive(0, 1, 8'h81, 0);
        drive(0, 1, 8'h82, 0);
        drive(0, 1, 8'h83, 0);
        drive(0, 1, 8'hEE, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 1);

        // Wrap-around with interleaved reads
        for (int i = 0; i < 20; i++) drive(0, 1, 8'(8'h60 + i), (i % 2) == 1);
        for (int i = 0; i < 6; i++) drive(0, 0, '0, 1);

        // Reset mid-operation
        drive(0, 1, 8'hC1, 0);
        drive(0, 1, 8'hC2, 0);
        drive(0, 1, 8'hC3, 0);
        drive(1, 1, 8'hC4, 1);
        drive(0, 1, 8'hA5, 0);
        drive(0, 0, '0, 1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  8'($urandom), $urandom_range(0, 1) == 1);
        for (int i = 0; i < 5; i++) drive(0, 0, '0, 1);

        @(negedge clk_i);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
